// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared states and protocol constants for the command controller
package ctrl_pkg;
  typedef enum logic [3:0] {IDLE, ACK, LOAD, START, WAIT, HDR, DIGEST, CHAR, EOL} state_t;
  localparam logic [7:0] CMD_LOAD   = 8'h31;
  localparam logic [7:0] CMD_HASH   = 8'h32;
  localparam logic [7:0] CMD_STATUS = 8'h33;
  localparam logic [7:0] RSP_HDR    = 8'h4C;
  localparam logic [7:0] RSP_EOL    = 8'h0A;
  localparam logic [7:0] RSP_OK     = 8'h4B;
  localparam logic [7:0] RSP_ERR    = 8'h45;
  localparam logic [7:0] RSP_TMO    = 8'h54;
  localparam logic [7:0] RSP_ZERO   = 8'h30;
endpackage

// File: rtl/nibble_to_ascii.sv
// nibble_to_ascii: 4-bit value to uppercase ASCII hex character
module nibble_to_ascii (
  input  logic [3:0] n,
  output logic [7:0] a
);
  always_comb a = (n < 4'd10) ? 8'h30 + {4'h0, n} : 8'h37 + {4'h0, n};
endmodule

// File: rtl/command_controller.sv
// command_controller: frame ack, hash core dispatch and ASCII response streaming
module command_controller
  import ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int TIMER_W        = 13
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ready,
  input  logic [7:0]   command,
  input  logic [15:0]  data_count,
  input  logic [255:0] buffer,
  output logic         data_request,
  output logic         core_start,
  output logic [255:0] core_data,
  input  logic         core_busy,
  input  logic         core_done,
  input  logic [255:0] core_digest,
  output logic [7:0]   tx_byte,
  output logic         tx_valid,
  input  logic         tx_ready,
  output logic [3:0]   state_dbg
);
  localparam logic [TIMER_W-1:0] TMAX = TIMER_W'(TIMEOUT_CYCLES - 1);
  state_t state;
  logic [7:0] cmd, payload, hex_ch;
  logic [15:0] cnt;
  logic [255:0] blk, dig, sh;
  logic loaded, is_dig;
  logic [TIMER_W-1:0] timer;
  logic [5:0] idx, next_idx;
  always_comb begin
    next_idx = (state == DIGEST) ? idx + 6'd1 : idx;
    sh = dig << {next_idx, 2'b00};
  end
  nibble_to_ascii u_hex (.n(sh[255:252]), .a(hex_ch));
  assign core_data = blk;
  assign state_dbg = state;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cmd <= '0;
      cnt <= '0;
      blk <= '0;
      dig <= '0;
      loaded <= 1'b0;
      is_dig <= 1'b0;
      payload <= '0;
      timer <= '0;
      idx <= '0;
      data_request <= 1'b0;
      core_start <= 1'b0;
      tx_byte <= '0;
      tx_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: if (ready) begin
          cmd <= command;
          cnt <= data_count;
          data_request <= 1'b1;
          state <= ACK;
        end
        ACK: begin
          data_request <= 1'b0;
          if (cmd == CMD_LOAD && cnt == 16'd64) state <= LOAD;
          else if (cmd == CMD_HASH && loaded) state <= START;
          else begin
            payload <= (cmd == CMD_STATUS) ? RSP_ZERO + {7'b0, loaded} : RSP_ERR;
            is_dig <= 1'b0;
            tx_byte <= RSP_HDR;
            tx_valid <= 1'b1;
            state <= HDR;
          end
        end
        LOAD: begin
          blk <= buffer;
          loaded <= 1'b1;
          payload <= RSP_OK;
          is_dig <= 1'b0;
          tx_byte <= RSP_HDR;
          tx_valid <= 1'b1;
          state <= HDR;
        end
        START: if (!core_busy) begin
          core_start <= 1'b1;
          timer <= '0;
          state <= WAIT;
        end
        WAIT: begin
          core_start <= 1'b0;
          timer <= timer + 1'b1;
          // a done pulse on the final timeout cycle still delivers the digest
          if (core_done || timer == TMAX) begin
            dig <= core_digest;
            is_dig <= core_done;
            payload <= RSP_TMO;
            tx_byte <= RSP_HDR;
            tx_valid <= 1'b1;
            state <= HDR;
          end
        end
        HDR: if (tx_ready) begin
          tx_byte <= is_dig ? hex_ch : payload;
          state <= is_dig ? DIGEST : CHAR;
        end
        DIGEST: if (tx_ready) begin
          idx <= idx + 6'd1;
          tx_byte <= (idx == 6'd63) ? RSP_EOL : hex_ch;
          state <= (idx == 6'd63) ? EOL : DIGEST;
        end
        CHAR: if (tx_ready) begin
          tx_byte <= RSP_EOL;
          state <= EOL;
        end
        EOL: if (tx_ready) begin
          tx_byte <= '0;
          tx_valid <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/command_controller.md
Name: command_controller

Overview:
- Sequences the host command path: consumes each frame completed by input_handler, acknowledges it, dispatches it to the SHA-256 hash core, and streams an ASCII response to the UART transmitter.
- Sits between input_handler (upstream), the hash core (side) and the UART tx byte interface (downstream).
- One command is in flight at a time.

Parameters:
- TIMEOUT_CYCLES, 4096: maximum cycles spent in WAIT for core_done before the timeout response is sent.
- TIMER_W, 13: width of the timeout counter; must satisfy 2^TIMER_W > TIMEOUT_CYCLES.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- ready  in  1  input_handler has a complete frame
- command  in  8  command byte of the frame (ASCII)
- data_count  in  16  number of hex characters received
- buffer  in  256  frame payload
- data_request  out  1  one-cycle pulse that consumes the frame in input_handler
- core_start  out  1  one-cycle start pulse to the hash core
- core_data  out  256  latched block presented to the core
- core_busy  in  1  core is computing
- core_done  in  1  one-cycle pulse; core_digest is valid in the same cycle
- core_digest  in  256  hash result
- tx_byte  out  8  response byte
- tx_valid  out  1  tx_byte is valid
- tx_ready  in  1  transmitter accepts the byte
- state_dbg  out  4  current FSM state encoding

Behaviour:
- Reset: every output is 0; the block register is cleared; loaded=0; state=IDLE. A reset asserted mid-operation aborts immediately, with no partial response and tx_valid=0 on the next cycle.
- Tx handshake:
  - A byte transfers on a cycle where tx_valid && tx_ready.
  - tx_byte must stay stable while tx_valid && !tx_ready.
  - tx_valid is never dropped before the transfer completes.
- Response framing: header 'L' (0x4C), then payload, then terminator 0x0A.
- IDLE: when ready=1, latch command and data_count, then go to ACK.
- ACK: data_request=1 for exactly one cycle. Decode the latched command:
  - 0x31 (LOAD): if data_count==64, go to LOAD; otherwise go to HDR with payload 'E'.
  - 0x32 (HASH): if loaded=1, go to START; otherwise go to HDR with payload 'E'.
  - 0x33 (STATUS): go to HDR with payload '0'+loaded.
  - Any other value: go to HDR with payload 'E'.
- LOAD: block register <= buffer; loaded <= 1; go to HDR with payload 'K'.
- START: requires core_busy=0.
  - If core_busy=1, hold in START until it falls.
  - Then core_start=1 for one cycle, clear the timer, go to WAIT.
- WAIT: the timer increments every cycle.
  - core_done=1: capture core_digest and go to HDR with the digest payload.
  - Timer reaches TIMEOUT_CYCLES-1 without core_done: go to HDR with payload 'T'.
  - core_done and timeout in the same cycle: core_done wins.
- HDR: send 'L'. Then:
  - Digest payload: go to DIGEST.
  - Single-character payload: go to CHAR.
- DIGEST: 64 ASCII hex characters, most significant nibble (bits 255:252) first.
  - Encoding: nibble 0-9 maps to 0x30+n; nibble A-F maps to 0x37+n (uppercase).
  - A 6-bit index advances only on a completed transfer and wraps 63 -> 0 on exit to EOL.
- CHAR: send one payload byte, then go to EOL.
- EOL: send 0x0A, then return to IDLE.
- While busy:
  - ready is ignored outside IDLE, and frames remain pending in input_handler.
  - A frame arriving during tx is served afterwards, because ready is held upstream.
- core_data is continuously driven from the block register.
- The controller ignores a core_done received outside WAIT.

Decomposition:
- Package ctrl_pkg holds:
  - the state enum (IDLE, ACK, LOAD, START, WAIT, HDR, DIGEST, CHAR, EOL);
  - the command constants CMD_LOAD=0x31, CMD_HASH=0x32, CMD_STATUS=0x33;
  - the response constants RSP_HDR=0x4C, RSP_EOL=0x0A, RSP_OK='K', RSP_ERR='E', RSP_TMO='T'.
- One sub-module, nibble_to_ascii: combinational 4-bit to 8-bit hex character converter.

Test Plan:
- Reset then STATUS (command 0x31+2): data_request pulses once; tx sequence is 0x4C, 0x30, 0x0A.
- LOAD with data_count=64 and buffer=0x0123...EF repeated: tx sequence is 4C, 4B, 0A; core_data equals buffer. A following STATUS returns 4C, 31, 0A.
- HASH after LOAD; core model asserts core_done 20 cycles after core_start with digest 0xBA7816BF...15AD:
  - core_start pulses exactly once;
  - tx sequence is 'L', then "BA7816BF...15AD" (64 chars), then 0x0A.
- HASH with no prior LOAD, and LOAD with data_count=16: each responds 4C, 45, 0A; core_start is never asserted.
- HASH with core_done withheld and TIMEOUT_CYCLES=16: response 4C, 54, 0A issued 16 cycles after core_start. A late core_done is then ignored.
- tx_ready toggled randomly during a digest response: no byte is dropped or duplicated. Reset asserted mid-digest: tx_valid=0 next cycle, state_dbg=IDLE.
